ct_pack_sequencer: RTL and testbench

Sequences ciphertext packing for the NewHope encryption datapath. On `start` it runs the polynomial byte encoder (packs `u`, 896 bytes), then the 3-bit compressor (packs `v`, 192 bytes). It multiplexes both units onto the single ciphertext byte-RAM write port and the shared polynomial-RAM read address. It owns start/done handshakes, the address offset, a write-count check and a hang watchdog.

---
 rtl/ct_pack_sequencer.sv | 135 +++++++++++++
 tb/tb_ct_pack_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_pack_sequencer.sv
// rtl/ct_pack_sequencer.sv - sequences the u-encoder then v-compressor onto the shared ciphertext/poly ports
// Owns start/done handshakes, the compressor address offset, the write-count check and a hang watchdog.
module ct_pack_sequencer #(
    parameter int ENC_BYTES = 896,
    parameter int CMP_BYTES = 192,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        enc_start,
    input  logic        enc_done,
    input  logic [9:0]  enc_byte_addr,
    input  logic [7:0]  enc_byte_di,
    input  logic        enc_byte_we,
    input  logic [8:0]  enc_poly_addra,
    output logic        cmp_start,
    input  logic        cmp_done,
    input  logic [7:0]  cmp_byte_addr,
    input  logic [7:0]  cmp_byte_di,
    input  logic        cmp_byte_we,
    input  logic [8:0]  cmp_poly_addra,
    output logic [10:0] ct_addr,
    output logic [7:0]  ct_di,
    output logic        ct_we,
    output logic [9:0]  poly_addra
);

    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [10:0]     TOTAL    = 11'(ENC_BYTES + CMP_BYTES);
    localparam logic [10:0]     CMP_BASE = 11'(ENC_BYTES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_ENC = 3'd1,
        WAIT_ENC  = 3'd2,
        START_CMP = 3'd3,
        WAIT_CMP  = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [10:0]     r_wr_cnt;
    logic [WD_W-1:0] r_wdog;
    logic            r_error;

    logic w_enc_sel;
    logic w_cmp_sel;
    logic w_waiting;
    logic w_timeout;
    logic w_accept;
    logic w_stray;
    logic w_cnt_bad;

    assign w_enc_sel = (r_state == START_ENC) || (r_state == WAIT_ENC);
    assign w_cmp_sel = (r_state == START_CMP) || (r_state == WAIT_CMP);
    assign w_waiting = (r_state == WAIT_ENC) || (r_state == WAIT_CMP);
    // A done arriving on the last watchdog cycle still counts as success.
    assign w_timeout = w_waiting && (r_wdog == WD_LAST)
                       && !((r_state == WAIT_ENC) && enc_done)
                       && !((r_state == WAIT_CMP) && cmp_done);
    // FINISH is the done cycle and behaves as idle, so back-to-back starts are taken there.
    assign w_accept  = start && ((r_state == IDLE) || (r_state == FINISH));
    assign w_stray   = (w_enc_sel && cmp_byte_we) || (w_cmp_sel && enc_byte_we);
    assign w_cnt_bad = (r_wr_cnt != TOTAL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (start) w_next = START_ENC;
            START_ENC: w_next = WAIT_ENC;
            WAIT_ENC: begin
                if (enc_done)       w_next = START_CMP;
                else if (w_timeout) w_next = FINISH;
            end
            START_CMP: w_next = WAIT_CMP;
            WAIT_CMP: begin
                if (cmp_done || w_timeout) w_next = FINISH;
            end
            FINISH:    w_next = start ? START_ENC : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        ct_addr    = 11'd0;
        ct_di      = 8'd0;
        ct_we      = 1'b0;
        poly_addra = 10'd0;
        if (w_enc_sel) begin
            ct_addr    = {1'b0, enc_byte_addr};
            ct_di      = enc_byte_di;
            ct_we      = enc_byte_we;
            poly_addra = {1'b0, enc_poly_addra};
        end else if (w_cmp_sel) begin
            ct_addr    = CMP_BASE + {3'b000, cmp_byte_addr};
            ct_di      = cmp_byte_di;
            ct_we      = cmp_byte_we;
            poly_addra = {1'b1, cmp_poly_addra};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_wr_cnt <= 11'd0;
            r_wdog   <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wdog  <= w_waiting ? r_wdog + WD_W'(1) : '0;
            if (w_accept) begin
                r_wr_cnt <= 11'd0;
                r_error  <= 1'b0;
            end else begin
                if (ct_we) r_wr_cnt <= r_wr_cnt + 11'd1;
                if (w_stray || w_timeout || ((r_state == FINISH) && w_cnt_bad))
                    r_error <= 1'b1;
            end
        end
    end

    assign busy      = w_enc_sel || w_cmp_sel;
    assign done      = (r_state == FINISH);
    // The count check folds in combinationally so error is valid alongside done.
    assign error     = r_error || ((r_state == FINISH) && w_cnt_bad);
    assign enc_start = (r_state == START_ENC);
    assign cmp_start = (r_state == START_CMP);

endmodule

// File: tb/tb_ct_pack_sequencer.sv
// tb/tb_ct_pack_sequencer.sv - directed bench for ct_pack_sequencer
// Main instance uses default parameters; a second instance with TIMEOUT=20 covers the watchdog.
module tb_ct_pack_sequencer;

    logic clk;
    logic rst;
    logic start, enc_done, enc_byte_we, cmp_done, cmp_byte_we;
    logic [9:0]  enc_byte_addr;
    logic [7:0]  enc_byte_di, cmp_byte_addr, cmp_byte_di;
    logic [8:0]  enc_poly_addra, cmp_poly_addra;
    logic busy, done, error, enc_start, cmp_start, ct_we;
    logic [10:0] ct_addr;
    logic [7:0]  ct_di;
    logic [9:0]  poly_addra;

    logic wd_start;
    logic wd_busy, wd_done, wd_error, wd_enc_start, wd_cmp_start, wd_ct_we;
    logic [10:0] wd_ct_addr;
    logic [7:0]  wd_ct_di;
    logic [9:0]  wd_poly_addra;

    int total = 0;
    int bad = 0;
    int sb [0:2047];
    int data_bad = 0;
    bit wd_cmp_seen = 0;

    ct_pack_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .enc_start(enc_start), .enc_done(enc_done), .enc_byte_addr(enc_byte_addr),
        .enc_byte_di(enc_byte_di), .enc_byte_we(enc_byte_we), .enc_poly_addra(enc_poly_addra),
        .cmp_start(cmp_start), .cmp_done(cmp_done), .cmp_byte_addr(cmp_byte_addr),
        .cmp_byte_di(cmp_byte_di), .cmp_byte_we(cmp_byte_we), .cmp_poly_addra(cmp_poly_addra),
        .ct_addr(ct_addr), .ct_di(ct_di), .ct_we(ct_we), .poly_addra(poly_addra)
    );

    ct_pack_sequencer #(.TIMEOUT(20)) dut_wd (
        .clk(clk), .rst(rst), .start(wd_start), .busy(wd_busy), .done(wd_done), .error(wd_error),
        .enc_start(wd_enc_start), .enc_done(1'b0), .enc_byte_addr(10'd0),
        .enc_byte_di(8'd0), .enc_byte_we(1'b0), .enc_poly_addra(9'd0),
        .cmp_start(wd_cmp_start), .cmp_done(1'b0), .cmp_byte_addr(8'd0),
        .cmp_byte_di(8'd0), .cmp_byte_we(1'b0), .cmp_poly_addra(9'd0),
        .ct_addr(wd_ct_addr), .ct_di(wd_ct_di), .ct_we(wd_ct_we), .poly_addra(wd_poly_addra)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    function automatic logic [7:0] exp_data(input logic [10:0] a);
        logic [10:0] t;
        if (a < 11'd896) return a[7:0] ^ 8'h5A;
        t = a - 11'd896;
        return t[7:0] ^ 8'hC3;
    endfunction

    always @(posedge clk) begin
        if (ct_we) begin
            sb[ct_addr] = sb[ct_addr] + 1;
            if (ct_di !== exp_data(ct_addr)) data_bad = data_bad + 1;
        end
        if (wd_cmp_start) wd_cmp_seen = 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_clear();
        for (int a = 0; a < 2048; a++) sb[a] = 0;
        data_bad = 0;
    endtask

    task automatic sb_check();
        int wrong;
        wrong = 0;
        for (int a = 0; a < 2048; a++)
            if (sb[a] != ((a < 1088) ? 1 : 0)) wrong++;
        chk("sb_each_once", wrong, 0);
        chk("sb_data", data_bad, 0);
    endtask

    // Called in the START_ENC cycle; returns in the done cycle with inputs idle.
    task automatic run_body(input int n_cmp);
        tick();
        for (int i = 0; i < 896; i++) begin
            enc_byte_we = 1'b1;
            enc_byte_addr = 10'(i);
            enc_byte_di = 8'(i) ^ 8'h5A;
            enc_poly_addra = 9'(i);
            start = (i == 5);
            #1;
            if (i == 0) chk("enc_first_addr", ct_addr, 0);
            if (i == 6) begin
                chk("ign_start_enc", enc_start, 0);
                chk("ign_start_busy", busy, 1);
            end
            tick();
        end
        enc_byte_we = 1'b0;
        start = 1'b0;
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        tick();
        for (int i = 0; i < n_cmp; i++) begin
            cmp_byte_we = 1'b1;
            cmp_byte_addr = 8'(i);
            cmp_byte_di = 8'(i) ^ 8'hC3;
            cmp_poly_addra = 9'(i);
            cmp_done = (i == n_cmp - 1);
            #1;
            if (i == 0) begin
                chk("cmp_first_addr", ct_addr, 896);
                chk("cmp_bank", poly_addra[9], 1);
            end
            if (i == 191) chk("cmp_last_addr", ct_addr, 1087);
            tick();
        end
        cmp_byte_we = 1'b0;
        cmp_done = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start = 0; enc_done = 0; enc_byte_we = 0; cmp_done = 0; cmp_byte_we = 0;
        enc_byte_addr = 0; enc_byte_di = 0; cmp_byte_addr = 0; cmp_byte_di = 0;
        enc_poly_addra = 0; cmp_poly_addra = 0; wd_start = 0;
        sb_clear();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_starts", {enc_start, cmp_start}, 0);
        chk("rst_mux", {ct_we, ct_addr, ct_di, poly_addra}, 0);
        rst = 1'b1;
        tick();

        // Handshake latency, stray write, and a short run that must flag error.
        enc_poly_addra = 9'h1AB;
        cmp_poly_addra = 9'h055;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_enc_start", enc_start, 1);
        chk("lat_busy", busy, 1);
        chk("lat_cmp_start0", cmp_start, 0);
        for (int j = 1; j <= 29; j++) begin
            tick();
            cmp_byte_we = (j == 3);
            cmp_byte_addr = 8'd5;
            enc_done = (j == 29);
            #1;
            if (j == 1) chk("lat_enc_start_off", enc_start, 0);
            if (j == 3) chk("stray_ct_we", ct_we, 0);
            if (j == 4) chk("stray_error", error, 1);
            if (j == 29) chk("lat_poly_enc", poly_addra, {1'b0, 9'h1AB});
        end
        tick();
        enc_done = 1'b0;
        chk("lat_cmp_start", cmp_start, 1);
        chk("lat_enc_off2", enc_start, 0);
        tick();
        chk("lat_cmp_start_off", cmp_start, 0);
        chk("lat_poly_cmp", poly_addra, {1'b1, 9'h055});
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        chk("a_done", done, 1);
        chk("a_busy", busy, 0);
        chk("a_error", error, 1);
        tick();
        chk("a_done_pulse", done, 0);
        chk("a_error_sticky", error, 1);

        // Nominal run, with back-to-back start taken in its done cycle.
        sb_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_error_clr", error, 0);
        run_body(192);
        chk("b_done", done, 1);
        chk("b_busy", busy, 0);
        chk("b_error", error, 0);
        sb_check();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("btb_enc_start", enc_start, 1);

        // Compressor short by one write.
        run_body(191);
        chk("c_done", done, 1);
        chk("c_error", error, 1);
        repeat (5) tick();
        chk("c_error_hold", error, 1);
        chk("c_busy_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_error_clr", error, 0);

        // Reset in WAIT_CMP.
        tick();
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        tick();
        cmp_byte_we = 1'b1;
        cmp_byte_addr = 8'd3;
        cmp_byte_di = 8'h3 ^ 8'hC3;
        #1;
        chk("d_fwd_we", ct_we, 1);
        chk("d_fwd_addr", ct_addr, 899);
        #2;
        rst = 1'b0;
        #1;
        chk("d_rst_busy", busy, 0);
        chk("d_rst_mux", {ct_we, ct_addr, ct_di, poly_addra}, 0);
        chk("d_rst_flags", {done, error, enc_start, cmp_start}, 0);
        cmp_byte_we = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        sb_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e_enc_start", enc_start, 1);
        run_body(192);
        chk("e_done", done, 1);
        chk("e_error", error, 0);
        sb_check();
        tick();

        // Watchdog on the TIMEOUT=20 instance.
        wd_start = 1'b1;
        tick();
        wd_start = 1'b0;
        chk("wd_enc_start", wd_enc_start, 1);
        n = 0;
        while (!wd_done && n < 100) begin
            tick();
            n++;
        end
        chk("wd_latency", n, 21);
        chk("wd_error", wd_error, 1);
        chk("wd_busy", wd_busy, 0);
        tick();
        chk("wd_no_cmp", wd_cmp_seen, 0);
        chk("wd_done_pulse", wd_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
